// File: rtl/ram4x4_controller.sv
// Request/response initiator for an array of binary RAM cells: turns one
// valid/ready request into a one-cycle word access and a held response.
module ram4x4_controller #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [WORDS-1:0]  ram_select,
    output logic              ram_rdwr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] WORDS_LIM = (ADDR_W + 1)'(WORDS);

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [WORDS-1:0]    ram_select_q, ram_select_d;
    logic                ram_rdwr_q, ram_rdwr_d;
    logic [DATA_W-1:0]   ram_in_q, ram_in_d;

    logic [WORDS-1:0]    req_onehot;
    logic                addr_oob;

    // Word decode of the incoming address; only used when the address is in range.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_decode
            assign req_onehot[gi] = (req_addr == ADDR_W'(gi));
        end
    endgenerate

    assign addr_oob = ({1'b0, req_addr} >= WORDS_LIM);

    // Outputs are computed for the state being entered, so every port is a flop.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        ram_select_d = '0;
        ram_rdwr_d   = 1'b1;
        ram_in_d     = '0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (addr_oob) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d      = WRITE;
                        ram_select_d = req_onehot;
                        ram_rdwr_d   = 1'b0;
                        ram_in_d     = req_wdata;
                    end else begin
                        state_d      = READ;
                        ram_select_d = req_onehot;
                    end
                end
            end

            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end

            READ: begin
                // Cell outputs are valid while select is held with rdwr = 1.
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ram_out;
                rsp_err_d   = 1'b0;
            end

            RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            ram_select_q <= '0;
            ram_rdwr_q   <= 1'b1;
            ram_in_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            ram_select_q <= ram_select_d;
            ram_rdwr_q   <= ram_rdwr_d;
            ram_in_q     <= ram_in_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign ram_select = ram_select_q;
    assign ram_rdwr   = ram_rdwr_q;
    assign ram_in     = ram_in_q;

endmodule

// File: tb/tb_ram4x4_controller.sv
// Directed bench for ram4x4_controller with a behavioural 4x4 cell array;
// a second instance with WORDS = 3 covers the out-of-range path.
module tb_ram4x4_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [3:0] req_wdata = 4'd0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [3:0] rsp_rdata, ram_select, ram_in, ram_out;
    logic       ram_rdwr;

    logic       b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_err, b_ram_rdwr;
    logic [1:0] b_req_addr = 2'd0;
    logic [3:0] b_rsp_rdata, b_ram_in;
    logic [2:0] b_ram_select;
    logic [3:0] b_ram_out = 4'hF;

    int vec = 0;
    int miss = 0;
    int wr_cycles = 0;

    always #5 clk = ~clk;

    ram4x4_controller #(.ADDR_W(2), .DATA_W(4), .WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_select(ram_select), .ram_rdwr(ram_rdwr),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    ram4x4_controller #(.ADDR_W(2), .DATA_W(4), .WORDS(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(1'b0),
        .req_addr(b_req_addr), .req_wdata(4'h0),
        .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .ram_select(b_ram_select), .ram_rdwr(b_ram_rdwr),
        .ram_in(b_ram_in), .ram_out(b_ram_out)
    );

    // Binary RAM cell array: capture on posedge when selected with rdwr = 0,
    // drive out only while selected with rdwr = 1.
    logic [3:0] mem [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_select[i] && !ram_rdwr) mem[i] <= ram_in;
    end
    always_comb begin
        ram_out = 4'h0;
        for (int i = 0; i < 4; i++)
            if (ram_select[i] && ram_rdwr) ram_out = ram_out | mem[i];
    end

    // Continuous write-safety watch on the array control lines.
    always @(negedge clk) begin
        if (!rst) begin
            vec++;
            if ((ram_select & (ram_select - 4'd1)) != 4'd0) begin
                miss++;
                $display("FAIL select_onehot: ram_select=%b, required one-hot or 0", ram_select);
            end
            if (!ram_rdwr) begin
                wr_cycles++;
                vec++;
                if ($countones(ram_select) != 1) begin
                    miss++;
                    $display("FAIL write_safety: ram_rdwr=0 with ram_select=%b, required exactly one bit", ram_select);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for req_ready, present one request for one edge, then withdraw it.
    task automatic accept(input logic we, input logic [1:0] a, input logic [3:0] d);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        vec++;
        if (!req_ready) begin
            miss++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick(); tick();
        vec++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, ram_select, ram_rdwr, ram_in} !== {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h0}) begin
            miss++;
            $display("FAIL reset_state: rdy=%b vld=%b rdata=%h err=%b sel=%b rdwr=%b in=%h, required 1 0 0 0 0000 1 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, ram_select, ram_rdwr, ram_in);
        end
        vec++;
        if ({b_req_ready, b_rsp_valid, b_ram_select, b_ram_rdwr} !== {1'b1, 1'b0, 3'b000, 1'b1}) begin
            miss++;
            $display("FAIL reset_state_b: rdy=%b vld=%b sel=%b rdwr=%b, required 1 0 000 1",
                     b_req_ready, b_rsp_valid, b_ram_select, b_ram_rdwr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        wr_cycles = 0;
        accept(1'b1, 2'd2, 4'b1010);
        vec++;
        if ({ram_select, ram_rdwr, ram_in, req_ready, rsp_valid} !== {4'b0100, 1'b0, 4'b1010, 1'b0, 1'b0}) begin
            miss++;
            $display("FAIL wr_access: sel=%b rdwr=%b in=%b rdy=%b vld=%b, required 0100 0 1010 0 0",
                     ram_select, ram_rdwr, ram_in, req_ready, rsp_valid);
        end
        tick();
        vec++;
        if ({rsp_valid, rsp_err, rsp_rdata, ram_select, ram_rdwr, ram_in} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0}) begin
            miss++;
            $display("FAIL wr_resp: vld=%b err=%b rdata=%h sel=%b rdwr=%b in=%h, required 1 0 0 0000 1 0",
                     rsp_valid, rsp_err, rsp_rdata, ram_select, ram_rdwr, ram_in);
        end
        tick();
        vec++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miss++;
            $display("FAIL wr_done: vld=%b rdy=%b, required 0 1", rsp_valid, req_ready);
        end
        accept(1'b0, 2'd2, 4'h0);
        vec++;
        if ({ram_select, ram_rdwr, ram_in} !== {4'b0100, 1'b1, 4'h0}) begin
            miss++;
            $display("FAIL rd_access: sel=%b rdwr=%b in=%h, required 0100 1 0", ram_select, ram_rdwr, ram_in);
        end
        tick();
        vec++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 4'b1010}) begin
            miss++;
            $display("FAIL rd_resp: vld=%b err=%b rdata=%b, required 1 0 1010", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
        vec++;
        if (wr_cycles != 1) begin
            miss++;
            $display("FAIL wr_cycles: ram_rdwr low for %0d cycles, required 1", wr_cycles);
        end
    endtask

    task automatic test_all_words;
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 4'(1 << i);
            accept(1'b1, 2'(i), d);
            tick(); tick();
        end
        for (int i = 0; i < 4; i++) begin
            d = 4'(1 << i);
            accept(1'b0, 2'(i), 4'h0);
            tick();
            vec++;
            if ({rsp_valid, rsp_rdata} !== {1'b1, d}) begin
                miss++;
                $display("FAIL all_words[%0d]: vld=%b rdata=%h, required 1 %h", i, rsp_valid, rsp_rdata, d);
            end
            tick();
        end
    endtask

    task automatic test_overwrite;
        logic [3:0] exp_v [2];
        exp_v[0] = 4'hF;
        exp_v[1] = 4'h0;
        for (int k = 0; k < 2; k++) begin
            accept(1'b1, 2'd0, exp_v[k]);
            tick(); tick();
            accept(1'b0, 2'd0, 4'h0);
            tick();
            vec++;
            if (rsp_rdata !== exp_v[k]) begin
                miss++;
                $display("FAIL overwrite[%0d]: rdata=%h, required %h", k, rsp_rdata, exp_v[k]);
            end
            tick();
        end
    endtask

    task automatic test_stall;
        accept(1'b1, 2'd3, 4'h6);
        tick(); tick();
        rsp_ready = 1'b0;
        accept(1'b0, 2'd3, 4'h0);
        tick();
        for (int c = 0; c < 5; c++) begin
            vec++;
            if ({rsp_valid, rsp_rdata, req_ready, ram_select} !== {1'b1, 4'h6, 1'b0, 4'h0}) begin
                miss++;
                $display("FAIL stall[%0d]: vld=%b rdata=%h rdy=%b sel=%b, required 1 6 0 0000",
                         c, rsp_valid, rsp_rdata, req_ready, ram_select);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        vec++;
        if ({rsp_valid, req_ready, rsp_rdata} !== {1'b0, 1'b1, 4'h0}) begin
            miss++;
            $display("FAIL stall_release: vld=%b rdy=%b rdata=%h, required 0 1 0", rsp_valid, req_ready, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd2; req_wdata = 4'h0;
        tick();
        vec++;
        if (ram_select !== 4'b0100) begin
            miss++;
            $display("FAIL b2b_first: sel=%b, required 0100", ram_select);
        end
        tick(); tick();
        vec++;
        if (req_ready !== 1'b1) begin
            miss++;
            $display("FAIL b2b_idle: rdy=%b, required 1", req_ready);
        end
        tick();
        vec++;
        if ({ram_select, req_ready} !== {4'b0100, 1'b0}) begin
            miss++;
            $display("FAIL b2b_second: sel=%b rdy=%b, required 0100 0", ram_select, req_ready);
        end
        req_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_err;
        b_req_valid = 1'b1; b_req_addr = 2'd3;
        tick();
        b_req_valid = 1'b0;
        vec++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_rdata, b_ram_select} !== {1'b1, 1'b1, 4'h0, 3'b000}) begin
            miss++;
            $display("FAIL err_resp: vld=%b err=%b rdata=%h sel=%b, required 1 1 0 000",
                     b_rsp_valid, b_rsp_err, b_rsp_rdata, b_ram_select);
        end
        tick();
        vec++;
        if ({b_rsp_valid, b_req_ready, b_ram_select} !== {1'b0, 1'b1, 3'b000}) begin
            miss++;
            $display("FAIL err_done: vld=%b rdy=%b sel=%b, required 0 1 000", b_rsp_valid, b_req_ready, b_ram_select);
        end
        b_req_valid = 1'b1; b_req_addr = 2'd2;
        tick();
        b_req_valid = 1'b0;
        vec++;
        if (b_ram_select !== 3'b100) begin
            miss++;
            $display("FAIL inrange_sel: sel=%b, required 100", b_ram_select);
        end
        tick();
        vec++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_rdata} !== {1'b1, 1'b0, 4'hF}) begin
            miss++;
            $display("FAIL inrange_resp: vld=%b err=%b rdata=%h, required 1 0 f", b_rsp_valid, b_rsp_err, b_rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_write;
        accept(1'b1, 2'd1, 4'h5);
        rst = 1'b1;
        tick();
        vec++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, ram_select, ram_rdwr, ram_in} !== {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h0}) begin
            miss++;
            $display("FAIL midwr_reset: rdy=%b vld=%b rdata=%h err=%b sel=%b rdwr=%b in=%h, required 1 0 0 0 0000 1 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, ram_select, ram_rdwr, ram_in);
        end
        rst = 1'b0;
        tick();
        vec++;
        if (rsp_valid !== 1'b0) begin
            miss++;
            $display("FAIL midwr_norsp: vld=%b, required 0", rsp_valid);
        end
        accept(1'b0, 2'd1, 4'h0);
        tick();
        vec++;
        if (rsp_rdata !== 4'h5) begin
            miss++;
            $display("FAIL midwr_readback: rdata=%h, required 5", rsp_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_words();
        test_overwrite();
        test_stall();
        test_back_to_back();
        test_err();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
